// File: rtl/ram_half_responder.sv
// rtl/ram_half_responder.sv - 16-bit half-word RAM responder with post-reset clear and preload port
// One half-word per clock; reads return on the bus the cycle after the address.
module ram_half_responder #(
  parameter int          ADDR_W   = 18,
  parameter int          DEPTH    = 4096,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mc_ram_addr,
  input  logic              mc_ram_wre,
  inout  wire  [15:0]       mc_ram_data,
  input  logic              init_en,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [15:0]       init_data,
  output logic              ram_ready,
  output logic              ram_err
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic [15:0]   rd_q;
  logic [15:0]   mem [DEPTH];

  logic          mc_in, init_in;
  logic          we;
  logic [AW-1:0] wa;
  logic [15:0]   wd;

  // Full-width compare: addresses at or beyond DEPTH never alias into the array.
  assign mc_in   = (mc_ram_addr < DEPTH_A);
  assign init_in = (init_addr < DEPTH_A);

  // Pad driver follows wre combinationally so the bus is released the same cycle.
  assign mc_ram_data = (ram_ready && mc_ram_wre) ? rd_q : 16'bz;

  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    if (!reset) begin
      if (state == CLEAR) begin
        we = 1'b1;
        wa = clr_ptr;
      end else if (init_en) begin
        we = init_in;
        wa = init_addr[AW-1:0];
        wd = init_data;
      end else if (!mc_ram_wre) begin
        we = mc_in;
        wa = mc_ram_addr[AW-1:0];
        wd = mc_ram_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      rd_q      <= '0;
      ram_err   <= 1'b0;
      ram_ready <= 1'b0;
    end else begin
      ram_err <= 1'b0;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST) begin
            state     <= READY;
            ram_ready <= 1'b1;
            clr_ptr   <= '0;
          end
        end
        READY: begin
          ram_ready <= 1'b1;
          if (init_en) begin
            // A controller write lost to a preload is reported as well.
            ram_err <= !init_in || !mc_ram_wre;
          end else if (!mc_ram_wre) begin
            ram_err <= !mc_in;
          end else begin
            ram_err <= !mc_in;
            rd_q    <= mc_in ? mem[mc_ram_addr[AW-1:0]] : ERR_DATA;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_half_responder.sv
// tb/tb_ram_half_responder.sv - randomized self-checking bench for ram_half_responder
module tb_ram_half_responder;
  localparam int DEPTH = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] addr = '0;
  logic        wre = 1'b1;
  logic        init_en = 1'b0;
  logic [17:0] init_addr = '0;
  logic [15:0] init_data = '0;
  logic        drv_en = 1'b0;
  logic [15:0] drv_data = '0;
  wire  [15:0] bus;
  logic        ram_ready, ram_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_m [DEPTH];
  logic [15:0] last_rd;

  assign bus = drv_en ? drv_data : 16'bz;

  always #5 clock = ~clock;

  ram_half_responder dut (
    .clock(clock), .reset(reset), .mc_ram_addr(addr), .mc_ram_wre(wre),
    .mc_ram_data(bus), .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
    .ram_ready(ram_ready), .ram_err(ram_err)
  );

  task automatic model_clear();
    foreach (mem_m[i]) mem_m[i] = 16'h0000;
    last_rd = 16'h0000;
  endtask

  task automatic go_idle();
    wre = 1'b1; drv_en = 1'b0; init_en = 1'b0; addr = '0;
  endtask

  // One bus cycle: apply inputs, predict from the model, check just after the edge.
  task automatic step(input string name, input logic w, input int a, input logic [15:0] d,
                      input logic ie, input int ia, input logic [15:0] idt);
    logic exp_err;
    exp_err = 1'b0;
    addr = 18'(a); wre = w; drv_en = !w; drv_data = d;
    init_en = ie; init_addr = 18'(ia); init_data = idt;
    if (ie) begin
      if (ia < DEPTH) mem_m[ia] = idt; else exp_err = 1'b1;
      if (!w) exp_err = 1'b1;
    end else if (!w) begin
      if (a < DEPTH) mem_m[a] = d; else exp_err = 1'b1;
    end else begin
      if (a < DEPTH) last_rd = mem_m[a];
      else begin last_rd = 16'hDEAD; exp_err = 1'b1; end
    end
    @(posedge clock); #1;
    checks++;
    if (ram_err !== exp_err) begin
      errors++; $display("FAIL %s ram_err: got %b expected %b", name, ram_err, exp_err);
    end
    checks++;
    if (ram_ready !== 1'b1) begin
      errors++; $display("FAIL %s ram_ready: got %b expected 1", name, ram_ready);
    end
    checks++;
    if (w && bus !== last_rd) begin
      errors++; $display("FAIL %s read data @%0h: got %h expected %h", name, a, bus, last_rd);
    end else if (!w && bus !== d) begin
      errors++; $display("FAIL %s bus during write: got %h expected %h", name, bus, d);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ram_ready !== 1'b1 && n < DEPTH + 20) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n !== DEPTH) begin
      errors++; $display("FAIL %s clear length: got %0d cycles expected %0d", name, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    go_idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (ram_ready !== 1'b0 || ram_err !== 1'b0) begin
      errors++; $display("FAIL reset outputs: got ready=%b err=%b expected 0 0", ram_ready, ram_err);
    end
    reset = 1'b0;
    model_clear();
    wait_ready("reset");
    step("reset_read5", 1'b1, 5, 16'h0, 1'b0, 0, 16'h0);
  endtask

  task automatic test_split_word();
    step("split_wr_lo", 1'b0, 'h10, 16'h1234, 1'b0, 0, 16'h0);
    step("split_wr_hi", 1'b0, 'h11, 16'h5678, 1'b0, 0, 16'h0);
    step("split_rd_lo", 1'b1, 'h10, 16'h0, 1'b0, 0, 16'h0);
    step("split_rd_hi", 1'b1, 'h11, 16'h0, 1'b0, 0, 16'h0);
  endtask

  task automatic test_preload_priority();
    step("preload_collide", 1'b0, 'h20, 16'h5555, 1'b1, 'h20, 16'hAAAA);
    step("preload_read", 1'b1, 'h20, 16'h0, 1'b0, 0, 16'h0);
    step("preload_with_read", 1'b1, 'h20, 16'h0, 1'b1, 'h21, 16'hC0DE);
    step("preload_read21", 1'b1, 'h21, 16'h0, 1'b0, 0, 16'h0);
    step("preload_oor", 1'b1, 'h21, 16'h0, 1'b1, DEPTH, 16'h1111);
  endtask

  task automatic test_out_of_range();
    step("oor_rd_depth", 1'b1, DEPTH, 16'h0, 1'b0, 0, 16'h0);
    step("oor_wr_1", 1'b0, 1, 16'h7777, 1'b0, 0, 16'h0);
    step("oor_wr_top", 1'b0, DEPTH - 1, 16'h4242, 1'b0, 0, 16'h0);
    step("oor_wr_depth1", 1'b0, DEPTH + 1, 16'h9999, 1'b0, 0, 16'h0);
    step("oor_alias_rd1", 1'b1, 1, 16'h0, 1'b0, 0, 16'h0);
    step("oor_rd_top", 1'b1, DEPTH - 1, 16'h0, 1'b0, 0, 16'h0);
    step("oor_rd_far", 1'b1, 18'h3FFFF, 16'h0, 1'b0, 0, 16'h0);
  endtask

  task automatic test_reset_mid_op();
    step("mid_wr3", 1'b0, 3, 16'hBEEF, 1'b0, 0, 16'h0);
    step("mid_rd3", 1'b1, 3, 16'h0, 1'b0, 0, 16'h0);
    addr = 18'd3; wre = 1'b1; drv_en = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    wait_ready("reset_mid_ready");
    step("mid_rd3_after", 1'b1, 3, 16'h0, 1'b0, 0, 16'h0);
    step("mid_wr7", 1'b0, 7, 16'h5A5A, 1'b0, 0, 16'h0);
    go_idle();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (DEPTH / 2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    wait_ready("reset_mid_clear");
    step("midclr_rd7", 1'b1, 7, 16'h0, 1'b0, 0, 16'h0);
  endtask

  task automatic test_turnaround();
    for (int i = 0; i < 16; i++) begin
      int a;
      a = $urandom_range(0, 7);
      step("turn_wr", 1'b0, a, 16'($urandom), 1'b0, 0, 16'h0);
      step("turn_rd", 1'b1, $urandom_range(0, 7), 16'h0, 1'b0, 0, 16'h0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int op, a, ia;
      logic w;
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 7) == 0) ? DEPTH - 2 + $urandom_range(0, 4) : $urandom_range(0, 15);
      ia = ($urandom_range(0, 7) == 0) ? DEPTH - 1 + $urandom_range(0, 2) : $urandom_range(0, 15);
      w  = (op < 4) ? 1'b1 : (op < 8) ? 1'b0 : 1'($urandom_range(0, 1));
      step("random", w, a, 16'($urandom), (op >= 8), ia, 16'($urandom));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_split_word();
    test_preload_priority();
    test_out_of_range();
    test_turnaround();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
